// File: rtl/axi_rr_arb2.sv
// Two-to-one AXI4 arbiter: independent round-robin read and write arbitration with one
// outstanding transaction per direction; responses are routed by ownership, IDs pass through.
module axi_rr_arb2 #(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // Slave port 0
  input  logic [AXI_ID_WIDTH-1:0]   s0_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic [7:0]                s0_axi_awlen,
  input  logic [2:0]                s0_axi_awsize,
  input  logic [1:0]                s0_axi_awburst,
  input  logic                      s0_axi_awlock,
  input  logic [3:0]                s0_axi_awcache,
  input  logic [2:0]                s0_axi_awprot,
  input  logic                      s0_axi_awvalid,
  output logic                      s0_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] s0_axi_wstrb,
  input  logic                      s0_axi_wlast,
  input  logic                      s0_axi_wvalid,
  output logic                      s0_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]   s0_axi_bid,
  output logic [1:0]                s0_axi_bresp,
  output logic                      s0_axi_bvalid,
  input  logic                      s0_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]   s0_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic [7:0]                s0_axi_arlen,
  input  logic [2:0]                s0_axi_arsize,
  input  logic [1:0]                s0_axi_arburst,
  input  logic                      s0_axi_arlock,
  input  logic [3:0]                s0_axi_arcache,
  input  logic [2:0]                s0_axi_arprot,
  input  logic                      s0_axi_arvalid,
  output logic                      s0_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]   s0_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]                s0_axi_rresp,
  output logic                      s0_axi_rlast,
  output logic                      s0_axi_rvalid,
  input  logic                      s0_axi_rready,
  // Slave port 1
  input  logic [AXI_ID_WIDTH-1:0]   s1_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic [7:0]                s1_axi_awlen,
  input  logic [2:0]                s1_axi_awsize,
  input  logic [1:0]                s1_axi_awburst,
  input  logic                      s1_axi_awlock,
  input  logic [3:0]                s1_axi_awcache,
  input  logic [2:0]                s1_axi_awprot,
  input  logic                      s1_axi_awvalid,
  output logic                      s1_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] s1_axi_wstrb,
  input  logic                      s1_axi_wlast,
  input  logic                      s1_axi_wvalid,
  output logic                      s1_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]   s1_axi_bid,
  output logic [1:0]                s1_axi_bresp,
  output logic                      s1_axi_bvalid,
  input  logic                      s1_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]   s1_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic [7:0]                s1_axi_arlen,
  input  logic [2:0]                s1_axi_arsize,
  input  logic [1:0]                s1_axi_arburst,
  input  logic                      s1_axi_arlock,
  input  logic [3:0]                s1_axi_arcache,
  input  logic [2:0]                s1_axi_arprot,
  input  logic                      s1_axi_arvalid,
  output logic                      s1_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]   s1_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]                s1_axi_rresp,
  output logic                      s1_axi_rlast,
  output logic                      s1_axi_rvalid,
  input  logic                      s1_axi_rready,
  // Master port
  output logic [AXI_ID_WIDTH-1:0]   m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [AXI_STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  // Status
  output logic                      rd_owner_o,
  output logic                      rd_busy_o,
  output logic                      wr_owner_o,
  output logic                      wr_busy_o
);

  typedef enum logic [1:0] {RdIdle, RdAr, RdData} rd_state_e;
  typedef enum logic [1:0] {WrIdle, WrAw, WrData, WrResp} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic      rd_owner_q, rd_owner_d, rd_last_q, rd_last_d;
  logic      wr_owner_q, wr_owner_d, wr_last_q, wr_last_d;

  // Last-owner pointers reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= RdIdle;
      rd_owner_q <= 1'b0;
      rd_last_q  <= 1'b1;
      wr_state_q <= WrIdle;
      wr_owner_q <= 1'b0;
      wr_last_q  <= 1'b1;
    end else begin
      rd_state_q <= rd_state_d;
      rd_owner_q <= rd_owner_d;
      rd_last_q  <= rd_last_d;
      wr_state_q <= wr_state_d;
      wr_owner_q <= wr_owner_d;
      wr_last_q  <= wr_last_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_owner_d = rd_owner_q;
    rd_last_d  = rd_last_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (s0_axi_arvalid || s1_axi_arvalid) begin
          rd_owner_d = (s0_axi_arvalid && s1_axi_arvalid) ? ~rd_last_q : s1_axi_arvalid;
          rd_last_d  = rd_owner_d;
          rd_state_d = RdAr;
        end
      end
      RdAr:   if (m_axi_arvalid && m_axi_arready) rd_state_d = RdData;
      RdData: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_owner_d = wr_owner_q;
    wr_last_d  = wr_last_q;
    unique case (wr_state_q)
      WrIdle: begin
        if (s0_axi_awvalid || s1_axi_awvalid) begin
          wr_owner_d = (s0_axi_awvalid && s1_axi_awvalid) ? ~wr_last_q : s1_axi_awvalid;
          wr_last_d  = wr_owner_d;
          wr_state_d = WrAw;
        end
      end
      WrAw:   if (m_axi_awvalid && m_axi_awready) wr_state_d = WrData;
      WrData: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) wr_state_d = WrResp;
      WrResp: if (m_axi_bvalid && m_axi_bready) wr_state_d = WrIdle;
      default: wr_state_d = WrIdle;
    endcase
  end

  logic ar_en, r_en, aw_en, w_en, b_en;
  assign ar_en = (rd_state_q == RdAr);
  assign r_en  = (rd_state_q == RdData);
  assign aw_en = (wr_state_q == WrAw);
  assign w_en  = (wr_state_q == WrData);
  assign b_en  = (wr_state_q == WrResp);

  // Read address: payload always muxed, handshake gated by state and owner.
  assign m_axi_arid     = rd_owner_q ? s1_axi_arid    : s0_axi_arid;
  assign m_axi_araddr   = rd_owner_q ? s1_axi_araddr  : s0_axi_araddr;
  assign m_axi_arlen    = rd_owner_q ? s1_axi_arlen   : s0_axi_arlen;
  assign m_axi_arsize   = rd_owner_q ? s1_axi_arsize  : s0_axi_arsize;
  assign m_axi_arburst  = rd_owner_q ? s1_axi_arburst : s0_axi_arburst;
  assign m_axi_arlock   = rd_owner_q ? s1_axi_arlock  : s0_axi_arlock;
  assign m_axi_arcache  = rd_owner_q ? s1_axi_arcache : s0_axi_arcache;
  assign m_axi_arprot   = rd_owner_q ? s1_axi_arprot  : s0_axi_arprot;
  assign m_axi_arvalid  = ar_en && (rd_owner_q ? s1_axi_arvalid : s0_axi_arvalid);
  assign s0_axi_arready = ar_en && !rd_owner_q && m_axi_arready;
  assign s1_axi_arready = ar_en &&  rd_owner_q && m_axi_arready;

  assign s0_axi_rid     = m_axi_rid;
  assign s0_axi_rdata   = m_axi_rdata;
  assign s0_axi_rresp   = m_axi_rresp;
  assign s0_axi_rlast   = m_axi_rlast;
  assign s1_axi_rid     = m_axi_rid;
  assign s1_axi_rdata   = m_axi_rdata;
  assign s1_axi_rresp   = m_axi_rresp;
  assign s1_axi_rlast   = m_axi_rlast;
  assign s0_axi_rvalid  = r_en && !rd_owner_q && m_axi_rvalid;
  assign s1_axi_rvalid  = r_en &&  rd_owner_q && m_axi_rvalid;
  assign m_axi_rready   = r_en && (rd_owner_q ? s1_axi_rready : s0_axi_rready);

  assign m_axi_awid     = wr_owner_q ? s1_axi_awid    : s0_axi_awid;
  assign m_axi_awaddr   = wr_owner_q ? s1_axi_awaddr  : s0_axi_awaddr;
  assign m_axi_awlen    = wr_owner_q ? s1_axi_awlen   : s0_axi_awlen;
  assign m_axi_awsize   = wr_owner_q ? s1_axi_awsize  : s0_axi_awsize;
  assign m_axi_awburst  = wr_owner_q ? s1_axi_awburst : s0_axi_awburst;
  assign m_axi_awlock   = wr_owner_q ? s1_axi_awlock  : s0_axi_awlock;
  assign m_axi_awcache  = wr_owner_q ? s1_axi_awcache : s0_axi_awcache;
  assign m_axi_awprot   = wr_owner_q ? s1_axi_awprot  : s0_axi_awprot;
  assign m_axi_awvalid  = aw_en && (wr_owner_q ? s1_axi_awvalid : s0_axi_awvalid);
  assign s0_axi_awready = aw_en && !wr_owner_q && m_axi_awready;
  assign s1_axi_awready = aw_en &&  wr_owner_q && m_axi_awready;

  // W is only opened after the AW handshake, so early write data is held off.
  assign m_axi_wdata    = wr_owner_q ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb    = wr_owner_q ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast    = wr_owner_q ? s1_axi_wlast : s0_axi_wlast;
  assign m_axi_wvalid   = w_en && (wr_owner_q ? s1_axi_wvalid : s0_axi_wvalid);
  assign s0_axi_wready  = w_en && !wr_owner_q && m_axi_wready;
  assign s1_axi_wready  = w_en &&  wr_owner_q && m_axi_wready;

  assign s0_axi_bid     = m_axi_bid;
  assign s0_axi_bresp   = m_axi_bresp;
  assign s1_axi_bid     = m_axi_bid;
  assign s1_axi_bresp   = m_axi_bresp;
  assign s0_axi_bvalid  = b_en && !wr_owner_q && m_axi_bvalid;
  assign s1_axi_bvalid  = b_en &&  wr_owner_q && m_axi_bvalid;
  assign m_axi_bready   = b_en && (wr_owner_q ? s1_axi_bready : s0_axi_bready);

  assign rd_owner_o = rd_owner_q;
  assign rd_busy_o  = (rd_state_q != RdIdle);
  assign wr_owner_o = wr_owner_q;
  assign wr_busy_o  = (wr_state_q != WrIdle);

endmodule

// File: tb/tb_axi_rr_arb2.sv
// Directed self-checking bench for axi_rr_arb2: arbitration order, forwarding, W-before-AW
// gating, backpressure and asynchronous reset.
module tb_axi_rr_arb2;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned SW = DW / 8;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  logic [IW-1:0] s0_axi_awid, s1_axi_awid, m_axi_awid, s0_axi_arid, s1_axi_arid, m_axi_arid;
  logic [AW-1:0] s0_axi_awaddr, s1_axi_awaddr, m_axi_awaddr;
  logic [AW-1:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
  logic [7:0]    s0_axi_awlen, s1_axi_awlen, m_axi_awlen, s0_axi_arlen, s1_axi_arlen, m_axi_arlen;
  logic [2:0]    s0_axi_awsize, s1_axi_awsize, m_axi_awsize;
  logic [2:0]    s0_axi_arsize, s1_axi_arsize, m_axi_arsize;
  logic [1:0]    s0_axi_awburst, s1_axi_awburst, m_axi_awburst;
  logic [1:0]    s0_axi_arburst, s1_axi_arburst, m_axi_arburst;
  logic          s0_axi_awlock, s1_axi_awlock, m_axi_awlock;
  logic          s0_axi_arlock, s1_axi_arlock, m_axi_arlock;
  logic [3:0]    s0_axi_awcache, s1_axi_awcache, m_axi_awcache;
  logic [3:0]    s0_axi_arcache, s1_axi_arcache, m_axi_arcache;
  logic [2:0]    s0_axi_awprot, s1_axi_awprot, m_axi_awprot;
  logic [2:0]    s0_axi_arprot, s1_axi_arprot, m_axi_arprot;
  logic          s0_axi_awvalid, s1_axi_awvalid, m_axi_awvalid;
  logic          s0_axi_awready, s1_axi_awready, m_axi_awready;
  logic          s0_axi_arvalid, s1_axi_arvalid, m_axi_arvalid;
  logic          s0_axi_arready, s1_axi_arready, m_axi_arready;
  logic [DW-1:0] s0_axi_wdata, s1_axi_wdata, m_axi_wdata, s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
  logic [SW-1:0] s0_axi_wstrb, s1_axi_wstrb, m_axi_wstrb;
  logic          s0_axi_wlast, s1_axi_wlast, m_axi_wlast;
  logic          s0_axi_wvalid, s1_axi_wvalid, m_axi_wvalid;
  logic          s0_axi_wready, s1_axi_wready, m_axi_wready;
  logic [IW-1:0] s0_axi_bid, s1_axi_bid, m_axi_bid, s0_axi_rid, s1_axi_rid, m_axi_rid;
  logic [1:0]    s0_axi_bresp, s1_axi_bresp, m_axi_bresp, s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
  logic          s0_axi_bvalid, s1_axi_bvalid, m_axi_bvalid;
  logic          s0_axi_bready, s1_axi_bready, m_axi_bready;
  logic          s0_axi_rlast, s1_axi_rlast, m_axi_rlast;
  logic          s0_axi_rvalid, s1_axi_rvalid, m_axi_rvalid;
  logic          s0_axi_rready, s1_axi_rready, m_axi_rready;
  logic          rd_owner_o, rd_busy_o, wr_owner_o, wr_busy_o;

  // Every handshake output of the DUT plus the busy flags; all must be 0 in reset.
  logic [16:0] vr;
  assign vr = {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
               s0_axi_awready, s0_axi_wready, s0_axi_bvalid, s0_axi_arready, s0_axi_rvalid,
               s1_axi_awready, s1_axi_wready, s1_axi_bvalid, s1_axi_arready, s1_axi_rvalid,
               rd_busy_o, wr_busy_o};

  axi_rr_arb2 #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s0_axi_awid(s0_axi_awid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awlen(s0_axi_awlen),
    .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst),
    .s0_axi_awlock(s0_axi_awlock), .s0_axi_awcache(s0_axi_awcache),
    .s0_axi_awprot(s0_axi_awprot), .s0_axi_awvalid(s0_axi_awvalid),
    .s0_axi_awready(s0_axi_awready), .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb),
    .s0_axi_wlast(s0_axi_wlast), .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_bid(s0_axi_bid), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready), .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr),
    .s0_axi_arlen(s0_axi_arlen), .s0_axi_arsize(s0_axi_arsize),
    .s0_axi_arburst(s0_axi_arburst), .s0_axi_arlock(s0_axi_arlock),
    .s0_axi_arcache(s0_axi_arcache), .s0_axi_arprot(s0_axi_arprot),
    .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_awid(s1_axi_awid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awlen(s1_axi_awlen),
    .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst),
    .s1_axi_awlock(s1_axi_awlock), .s1_axi_awcache(s1_axi_awcache),
    .s1_axi_awprot(s1_axi_awprot), .s1_axi_awvalid(s1_axi_awvalid),
    .s1_axi_awready(s1_axi_awready), .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb),
    .s1_axi_wlast(s1_axi_wlast), .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_bid(s1_axi_bid), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready), .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr),
    .s1_axi_arlen(s1_axi_arlen), .s1_axi_arsize(s1_axi_arsize),
    .s1_axi_arburst(s1_axi_arburst), .s1_axi_arlock(s1_axi_arlock),
    .s1_axi_arcache(s1_axi_arcache), .s1_axi_arprot(s1_axi_arprot),
    .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .rd_owner_o(rd_owner_o), .rd_busy_o(rd_busy_o),
    .wr_owner_o(wr_owner_o), .wr_busy_o(wr_busy_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    s0_axi_awid = '0; s0_axi_awaddr = '0; s0_axi_awlen = '0; s0_axi_awsize = 3'd3;
    s0_axi_awburst = 2'd1; s0_axi_awlock = 1'b0; s0_axi_awcache = '0; s0_axi_awprot = '0;
    s0_axi_awvalid = 1'b0; s0_axi_wdata = '0; s0_axi_wstrb = '0; s0_axi_wlast = 1'b0;
    s0_axi_wvalid = 1'b0; s0_axi_bready = 1'b0; s0_axi_arid = '0; s0_axi_araddr = '0;
    s0_axi_arlen = '0; s0_axi_arsize = 3'd3; s0_axi_arburst = 2'd1; s0_axi_arlock = 1'b0;
    s0_axi_arcache = '0; s0_axi_arprot = '0; s0_axi_arvalid = 1'b0; s0_axi_rready = 1'b0;
    s1_axi_awid = '0; s1_axi_awaddr = '0; s1_axi_awlen = '0; s1_axi_awsize = 3'd3;
    s1_axi_awburst = 2'd1; s1_axi_awlock = 1'b0; s1_axi_awcache = '0; s1_axi_awprot = '0;
    s1_axi_awvalid = 1'b0; s1_axi_wdata = '0; s1_axi_wstrb = '0; s1_axi_wlast = 1'b0;
    s1_axi_wvalid = 1'b0; s1_axi_bready = 1'b0; s1_axi_arid = '0; s1_axi_araddr = '0;
    s1_axi_arlen = '0; s1_axi_arsize = 3'd3; s1_axi_arburst = 2'd1; s1_axi_arlock = 1'b0;
    s1_axi_arcache = '0; s1_axi_arprot = '0; s1_axi_arvalid = 1'b0; s1_axi_rready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bid = '0; m_axi_bresp = '0;
    m_axi_bvalid = 1'b0; m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
    m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    s0_axi_arvalid = 1'b1; s1_axi_awvalid = 1'b1; m_axi_rvalid = 1'b1; m_axi_bvalid = 1'b1;
    step();
    @(negedge clk_i);
    checks++;
    if (vr !== 17'h0) begin
      failures++; $display("FAIL rst_held_outputs got=%05h exp=00000", vr);
    end
    checks++;
    if ({rd_owner_o, wr_owner_o} !== 2'b00) begin
      failures++; $display("FAIL rst_owners got=%b exp=00", {rd_owner_o, wr_owner_o});
    end
    idle_inputs();
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (vr !== 17'h0) begin
      failures++; $display("FAIL rst_released_outputs got=%05h exp=00000", vr);
    end
  endtask

  task automatic test_single_read();
    step();
    s0_axi_arvalid = 1'b1; s0_axi_araddr = 64'h8000_0000; s0_axi_arlen = 8'd3;
    s0_axi_arid = 4'h3;
    @(negedge clk_i);
    checks++;
    if (m_axi_arvalid !== 1'b0) begin
      failures++; $display("FAIL sr_arvalid_early got=%b exp=0", m_axi_arvalid);
    end
    step();
    m_axi_arready = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({m_axi_arvalid, s0_axi_arready, s1_axi_arready, rd_busy_o, rd_owner_o} !== 5'b11010) begin
      failures++;
      $display("FAIL sr_ar_grant got=%b exp=11010",
               {m_axi_arvalid, s0_axi_arready, s1_axi_arready, rd_busy_o, rd_owner_o});
    end
    checks++;
    if ({m_axi_araddr, m_axi_arlen, m_axi_arid} !== {64'h8000_0000, 8'd3, 4'h3}) begin
      failures++;
      $display("FAIL sr_ar_fields got=%h/%h/%h exp=80000000/03/3",
               m_axi_araddr, m_axi_arlen, m_axi_arid);
    end
    step();
    s0_axi_arvalid = 1'b0; m_axi_arready = 1'b0; s0_axi_rready = 1'b1; m_axi_rid = 4'h3;
    for (int i = 0; i < 4; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata = 64'hD000 + 64'(i);
      m_axi_rlast = (i == 3);
      @(negedge clk_i);
      checks++;
      if ({s0_axi_rvalid, s1_axi_rvalid, s0_axi_rlast, m_axi_rready, s0_axi_rdata}
          !== {1'b1, 1'b0, (i == 3), 1'b1, 64'hD000 + 64'(i)}) begin
        failures++;
        $display("FAIL sr_beat%0d got=v%b/%b l%b rr%b d%h exp=v1/0 l%b rr1 d%h", i,
                 s0_axi_rvalid, s1_axi_rvalid, s0_axi_rlast, m_axi_rready, s0_axi_rdata,
                 (i == 3), 64'hD000 + 64'(i));
      end
      step();
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s0_axi_rready = 1'b0;
    @(negedge clk_i);
    checks++;
    if (rd_busy_o !== 1'b0) begin
      failures++; $display("FAIL sr_busy_after got=%b exp=0", rd_busy_o);
    end
  endtask

  task automatic test_read_tie();
    logic exp_owner;
    do_reset();
    s0_axi_arvalid = 1'b1; s0_axi_arid = 4'h1;
    s1_axi_arvalid = 1'b1; s1_axi_arid = 4'h2;
    s0_axi_rready = 1'b1; s1_axi_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_owner = k[0];
      @(negedge clk_i);
      checks++;
      if (rd_busy_o !== 1'b0) begin
        failures++; $display("FAIL tie%0d_idle got=%b exp=0", k, rd_busy_o);
      end
      step();
      m_axi_arready = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({rd_owner_o, m_axi_arvalid, m_axi_arid} !== {exp_owner, 1'b1, exp_owner ? 4'h2 : 4'h1})
      begin
        failures++;
        $display("FAIL tie%0d_owner got=%b/%b/%h exp=%b/1/%h", k, rd_owner_o, m_axi_arvalid,
                 m_axi_arid, exp_owner, exp_owner ? 4'h2 : 4'h1);
      end
      step();
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
      @(negedge clk_i);
      checks++;
      if ({s0_axi_rvalid, s1_axi_rvalid} !== (exp_owner ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL tie%0d_rvalid got=%b%b exp=%b", k, s0_axi_rvalid, s1_axi_rvalid,
                 exp_owner ? 2'b01 : 2'b10);
      end
      step();
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    end
    s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0; s0_axi_rready = 1'b0; s1_axi_rready = 1'b0;
  endtask

  task automatic test_concurrent();
    step();
    s1_axi_awvalid = 1'b1; s1_axi_awlen = 8'd1; s1_axi_awid = 4'h9;
    s1_axi_wvalid = 1'b1; s1_axi_wdata = 64'hA0; s1_axi_wstrb = 8'hFF; s1_axi_wlast = 1'b0;
    s0_axi_arvalid = 1'b1; s0_axi_arlen = 8'd1;
    @(negedge clk_i);
    checks++;
    if (s1_axi_wready !== 1'b0) begin
      failures++; $display("FAIL cc_wready_idle got=%b exp=0", s1_axi_wready);
    end
    step();
    m_axi_awready = 1'b1; m_axi_arready = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({wr_owner_o, rd_owner_o, wr_busy_o, rd_busy_o, m_axi_awvalid, m_axi_arvalid,
         m_axi_wvalid} !== 7'b1011110) begin
      failures++;
      $display("FAIL cc_owners got=%b exp=1011110", {wr_owner_o, rd_owner_o, wr_busy_o,
               rd_busy_o, m_axi_awvalid, m_axi_arvalid, m_axi_wvalid});
    end
    step();
    s1_axi_awvalid = 1'b0; s0_axi_arvalid = 1'b0; m_axi_awready = 1'b0; m_axi_arready = 1'b0;
    m_axi_wready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 64'h11; s0_axi_rready = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({m_axi_wvalid, s1_axi_wready, s0_axi_wready, m_axi_wdata, m_axi_wstrb}
        !== {3'b110, 64'hA0, 8'hFF}) begin
      failures++;
      $display("FAIL cc_w_beat0 got=%b%b%b %h %h exp=110 a0 ff", m_axi_wvalid, s1_axi_wready,
               s0_axi_wready, m_axi_wdata, m_axi_wstrb);
    end
    checks++;
    if ({s0_axi_rvalid, s1_axi_rvalid, s0_axi_rdata} !== {2'b10, 64'h11}) begin
      failures++;
      $display("FAIL cc_r_beat0 got=%b%b %h exp=10 11", s0_axi_rvalid, s1_axi_rvalid,
               s0_axi_rdata);
    end
    step();
    s1_axi_wdata = 64'hA1; s1_axi_wlast = 1'b1; m_axi_rdata = 64'h12; m_axi_rlast = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({m_axi_wlast, m_axi_wdata, s0_axi_rlast, s0_axi_rvalid} !== {1'b1, 64'hA1, 2'b11}) begin
      failures++;
      $display("FAIL cc_beat1 got=%b %h %b%b exp=1 a1 11", m_axi_wlast, m_axi_wdata,
               s0_axi_rlast, s0_axi_rvalid);
    end
    step();
    s1_axi_wvalid = 1'b0; s1_axi_wlast = 1'b0; m_axi_wready = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s0_axi_rready = 1'b0;
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00; m_axi_bid = 4'h9; s1_axi_bready = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({s1_axi_bvalid, s0_axi_bvalid, s1_axi_bresp, s1_axi_bid, m_axi_bready, rd_busy_o}
        !== {2'b10, 2'b00, 4'h9, 2'b10}) begin
      failures++;
      $display("FAIL cc_b got=%b%b %b %h %b%b exp=10 00 9 10", s1_axi_bvalid, s0_axi_bvalid,
               s1_axi_bresp, s1_axi_bid, m_axi_bready, rd_busy_o);
    end
    step();
    m_axi_bvalid = 1'b0; s1_axi_bready = 1'b0;
    @(negedge clk_i);
    checks++;
    if (wr_busy_o !== 1'b0) begin
      failures++; $display("FAIL cc_wr_done got=%b exp=0", wr_busy_o);
    end
  endtask

  task automatic test_w_before_aw();
    step();
    s0_axi_wvalid = 1'b1; s0_axi_wdata = 64'h55; s0_axi_wstrb = 8'h0F; s0_axi_wlast = 1'b1;
    m_axi_wready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++;
      if ({s0_axi_wready, m_axi_wvalid} !== 2'b00) begin
        failures++;
        $display("FAIL wa_early%0d got=%b%b exp=00", i, s0_axi_wready, m_axi_wvalid);
      end
      step();
    end
    s0_axi_awvalid = 1'b1; s0_axi_awaddr = 64'h1000; s0_axi_awid = 4'h5;
    step();
    m_axi_awready = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({m_axi_awvalid, s0_axi_awready, s0_axi_wready, m_axi_wvalid, wr_owner_o, wr_busy_o}
        !== 6'b110001) begin
      failures++;
      $display("FAIL wa_aw got=%b exp=110001", {m_axi_awvalid, s0_axi_awready, s0_axi_wready,
               m_axi_wvalid, wr_owner_o, wr_busy_o});
    end
    step();
    s0_axi_awvalid = 1'b0; m_axi_awready = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({s0_axi_wready, m_axi_wvalid, m_axi_wdata, m_axi_wstrb} !== {2'b11, 64'h55, 8'h0F}) begin
      failures++;
      $display("FAIL wa_w got=%b%b %h %h exp=11 55 0f", s0_axi_wready, m_axi_wvalid,
               m_axi_wdata, m_axi_wstrb);
    end
    step();
    s0_axi_wvalid = 1'b0; s0_axi_wlast = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10; m_axi_bid = 4'h5; s0_axi_bready = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({s0_axi_bvalid, s1_axi_bvalid, s0_axi_bresp, s0_axi_bid} !== {2'b10, 2'b10, 4'h5}) begin
      failures++;
      $display("FAIL wa_slverr got=%b%b %b %h exp=10 10 5", s0_axi_bvalid, s1_axi_bvalid,
               s0_axi_bresp, s0_axi_bid);
    end
    step();
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; s0_axi_bready = 1'b0;
  endtask

  task automatic test_backpressure();
    step();
    s0_axi_arvalid = 1'b1; s0_axi_arlen = 8'd0;
    step();
    s1_axi_arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if ({m_axi_arvalid, s0_axi_arready, s1_axi_arready, rd_owner_o} !== 4'b1000) begin
        failures++;
        $display("FAIL bp_ar%0d got=%b exp=1000", i,
                 {m_axi_arvalid, s0_axi_arready, s1_axi_arready, rd_owner_o});
      end
      step();
    end
    m_axi_arready = 1'b1;
    step();
    s0_axi_arvalid = 1'b0; m_axi_arready = 1'b0; s0_axi_rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if ({s0_axi_rvalid, m_axi_rready, rd_owner_o, rd_busy_o} !== 4'b0101) begin
        failures++;
        $display("FAIL bp_r%0d got=%b exp=0101", i,
                 {s0_axi_rvalid, m_axi_rready, rd_owner_o, rd_busy_o});
      end
      step();
    end
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    step();
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s0_axi_rready = 1'b0;
    step();
    @(negedge clk_i);
    checks++;
    if ({rd_owner_o, m_axi_arvalid} !== 2'b11) begin
      failures++; $display("FAIL bp_next_s1 got=%b%b exp=11", rd_owner_o, m_axi_arvalid);
    end
    s1_axi_arvalid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    s0_axi_arvalid = 1'b1; s0_axi_arlen = 8'd3;
    step();
    m_axi_arready = 1'b1;
    step();
    s0_axi_arvalid = 1'b0; m_axi_arready = 1'b0; s0_axi_rready = 1'b1; m_axi_rvalid = 1'b1;
    step();
    m_axi_rdata = 64'h2;
    @(negedge clk_i);
    checks++;
    if (s0_axi_rvalid !== 1'b1) begin
      failures++; $display("FAIL rmb_beat2 got=%b exp=1", s0_axi_rvalid);
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({vr, rd_owner_o, wr_owner_o} !== 19'h0) begin
      failures++;
      $display("FAIL rmb_async got=%05h/%b%b exp=00000/00", vr, rd_owner_o, wr_owner_o);
    end
    step();
    rst_i = 1'b0;
    idle_inputs();
    s1_axi_arvalid = 1'b1;
    step();
    @(negedge clk_i);
    checks++;
    if ({m_axi_arvalid, rd_owner_o} !== 2'b11) begin
      failures++; $display("FAIL rmb_regrant got=%b%b exp=11", m_axi_arvalid, rd_owner_o);
    end
    s1_axi_arvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_read_tie();
    test_concurrent();
    test_w_before_aw();
    test_backpressure();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rr_arb2.md
# axi_rr_arb2

Two-to-one AXI4 arbiter that shares the single flat `m_axi_*` master port between two requesters: port 0 carries the Ariane core traffic, port 1 a secondary master such as a debug or DMA engine. Read and write paths are arbitrated independently with round-robin priority. Each direction allows exactly one outstanding transaction, so responses are routed by ownership and IDs pass through unchanged. The block sits between the masters and the flat-signal AXI bridge to the memory system.

## Interface
- `AXI_DATA_WIDTH`, default 64: data width.
- `AXI_ADDR_WIDTH`, default 64: address width.
- `AXI_ID_WIDTH`, default 4: ID width, identical on all ports.
- `AXI_STRB_WIDTH`, localparam: `AXI_DATA_WIDTH/8`.
- `clk_i`, input, 1: the block's single clock.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `s0_axi_*`: slave port 0. Full AXI4 set (aw id/addr/len/size/burst/lock/cache/prot/valid/ready, w data/strb/last/valid/ready, b id/resp/valid/ready, ar equivalent to aw, r id/data/resp/last/valid/ready). Widths match `m_axi_*`, with directions mirrored.
- `s1_axi_*`: slave port 1, with the same signal set as port 0.
- `m_axi_*`: master port, with the same signal set as `s0_axi_*`. Directions are the master directions; for example, `m_axi_awvalid` is an output.
- `rd_owner_o`, output, 1: current read owner. Valid when `rd_busy_o` is high.
- `rd_busy_o`, output, 1: high when the read FSM is not in R_IDLE.
- `wr_owner_o`, output, 1: current write owner. Valid when `wr_busy_o` is high.
- `wr_busy_o`, output, 1: high when the write FSM is not in W_IDLE.

## Operation
**Read FSM** (R_IDLE → R_AR → R_DATA → R_IDLE)
- In R_IDLE, sample `s0_arvalid` and `s1_arvalid`.
  - If only one is set, grant it.
  - If both are set, grant the port other than `rd_last`.
  - On a grant, register the owner, set `rd_last` to the owner, and go to R_AR.
- In R_AR:
  - `m_axi_ar*` is a mux of the owner's AR fields.
  - `m_axi_arvalid` equals the owner's `arvalid`.
  - The owner's `arready` equals `m_axi_arready`.
  - On handshake, go to R_DATA.
- In R_DATA:
  - `m_axi_r*` is routed to the owner: the owner's `rvalid` equals `m_axi_rvalid`, and `m_axi_rready` equals the owner's `rready`.
  - On a handshake with `rlast` high, go to R_IDLE.
- **Write FSM** (W_IDLE → W_AW → W_DATA → W_RESP → W_IDLE): the same arbitration applies, using `awvalid` and the pointer `wr_last`.
  - W_AW forwards AW and advances on the AW handshake.
  - W_DATA forwards the owner's W and advances on the W handshake with `wlast` high.
  - W_RESP routes B to the owner and returns to W_IDLE on the B handshake.
- **W before AW:** W from a port is never accepted before that port's AW handshake completes. Holding `wready` low is legal slave behaviour.
- **Non-owners:** the non-owner port and idle channels see all ready and valid outputs at 0. A non-owner's data outputs are don't-care.
- **Responses:** `m_axi` resp codes (SLVERR/DECERR) pass to the owner unmodified. The arbiter never generates responses.
- **Simultaneous events:** read and write FSMs are fully independent. Port 0 may own reads while port 1 owns writes in the same cycle.
- **Reset:**
  - Both FSMs go to IDLE.
  - `rd_last` and `wr_last` reset to 1, so port 0 wins the first tie.
  - Owners reset to 0.
- **Reset mid-burst:** an in-flight transfer is abandoned. All valid and ready outputs drop asynchronously, with no attempt to complete the burst.

## Timing
- **Reset values:** every `*valid`, `*ready`, `rd_busy_o` and `wr_busy_o` output is 0. Owners are 0.
- **Arbitration latency:** one cycle. A request asserted in cycle N with the FSM idle appears on `m_axi_arvalid` or `m_axi_awvalid` in cycle N+1.
- **Forwarding:** once an FSM is in a forwarding state, forwarding is combinational with zero added latency, and the full `m_axi` bandwidth is available within a burst.
- **Return to idle:** the cycle after the final handshake (R last, or B), the FSM is in IDLE. The next grant is decided in that cycle, and the next AR or AW is presented one cycle later. The minimum gap between transactions is therefore one idle cycle.
- **Grant stability:** a grant never changes before the transaction completes.

## Test plan
- **Single read:** port 0 issues AR with addr=0x8000_0000, len=3; the slave returns 4 beats, last on beat 4.
  - `m_axi_arvalid` rises one cycle after the request.
  - All 4 beats are delivered to port 0 only.
  - `rd_busy_o` is 0 the cycle after the last beat.
- **Read tie after reset:** both ports assert AR with len=0 in the same cycle.
  - Port 0 is served first, then port 1.
  - Repeating the tie then yields the order 0, 1, 0, 1.
- **Concurrent read and write:** port 1 issues a write (len=1, strb=0xFF, bresp=OKAY) while port 0 performs a read burst.
  - Both complete without interference.
  - `wr_owner_o`=1 and `rd_owner_o`=0 concurrently.
- **W before AW:** port 0 asserts W before AW.
  - `s0_wready` stays 0 until the AW handshake, then the data passes through.
  - Port 0 receives B with resp=SLVERR.
- **Backpressure:** the slave holds `arready` and `rready` low for 5 cycles.
  - The owner's ready outputs stay 0 for those cycles.
  - The grant does not switch while port 1 asserts `arvalid`.
- **Reset mid-burst:** assert `rst_i` during beat 2 of a 4-beat read.
  - All outputs go to their reset values immediately.
  - After release, a new request from port 1 is granted within 1 cycle.
